// File: rtl/key_debouncer.sv
// key_debouncer: per-key two-flop synchronizer plus confirm-counter FSM.
// Turns raw active-low KEY pins into a clean active-high level and
// single-cycle press/release strobes once a level has been stable for
// DEBOUNCE_CYCLES consecutive synchronized samples.
module key_debouncer #(
  parameter int N_KEYS          = 2,
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int CNT_W           = 20
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N_KEYS-1:0] key_n,
  output logic [N_KEYS-1:0] key_level,
  output logic [N_KEYS-1:0] press_pulse,
  output logic [N_KEYS-1:0] release_pulse
);

  typedef enum logic [1:0] {
    ST_UP,
    ST_CONFIRM_DOWN,
    ST_DOWN,
    ST_CONFIRM_UP
  } state_t;

  localparam logic [CNT_W-1:0] LP_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] LP_ONE  = CNT_W'(1);

  logic [N_KEYS-1:0] r_sync1;
  logic [N_KEYS-1:0] r_sync2;
  logic [N_KEYS-1:0] w_s;

  // Two-flop synchronizer; reset to the released (high) level
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync1 <= '1;
      r_sync2 <= '1;
    end else begin
      r_sync1 <= key_n;
      r_sync2 <= r_sync1;
    end
  end

  assign w_s = ~r_sync2;

  for (genvar g = 0; g < N_KEYS; g++) begin : g_key
    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_level;
    logic             r_press;
    logic             r_release;

    // Per-key debounce FSM with registered level and one-cycle strobes
    always_ff @(posedge clk) begin
      if (rst) begin
        r_state   <= ST_UP;
        r_cnt     <= '0;
        r_level   <= 1'b0;
        r_press   <= 1'b0;
        r_release <= 1'b0;
      end else begin
        r_press   <= 1'b0;
        r_release <= 1'b0;
        unique case (r_state)
          ST_UP: begin
            r_level <= 1'b0;
            if (w_s[g]) begin
              r_state <= ST_CONFIRM_DOWN;
              r_cnt   <= LP_ONE;
            end else begin
              r_cnt   <= '0;
            end
          end
          ST_CONFIRM_DOWN: begin
            if (!w_s[g]) begin
              // single opposite sample aborts the change entirely
              r_state <= ST_UP;
              r_cnt   <= '0;
            end else if (r_cnt == LP_LAST) begin
              r_state <= ST_DOWN;
              r_cnt   <= '0;
              r_level <= 1'b1;
              r_press <= 1'b1;
            end else begin
              r_cnt   <= r_cnt + LP_ONE;
            end
          end
          ST_DOWN: begin
            r_level <= 1'b1;
            if (!w_s[g]) begin
              r_state <= ST_CONFIRM_UP;
              r_cnt   <= LP_ONE;
            end else begin
              r_cnt   <= '0;
            end
          end
          ST_CONFIRM_UP: begin
            if (w_s[g]) begin
              r_state <= ST_DOWN;
              r_cnt   <= '0;
            end else if (r_cnt == LP_LAST) begin
              r_state   <= ST_UP;
              r_cnt     <= '0;
              r_level   <= 1'b0;
              r_release <= 1'b1;
            end else begin
              r_cnt     <= r_cnt + LP_ONE;
            end
          end
          default: begin
            r_state <= ST_UP;
            r_cnt   <= '0;
            r_level <= 1'b0;
          end
        endcase
      end
    end

    assign key_level[g]     = r_level;
    assign press_pulse[g]   = r_press;
    assign release_pulse[g] = r_release;
  end

endmodule

// File: tb/tb_key_debouncer.sv
// Directed self-checking bench for key_debouncer (DEBOUNCE_CYCLES=4, 2 keys).
module tb_key_debouncer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] key_n = 2'b11;
  logic [1:0] key_level;
  logic [1:0] press_pulse;
  logic [1:0] release_pulse;

  int n_checks = 0;
  int n_fail   = 0;

  key_debouncer #(
    .N_KEYS(2),
    .DEBOUNCE_CYCLES(4),
    .CNT_W(3)
  ) dut (
    .clk(clk),
    .rst(rst),
    .key_n(key_n),
    .key_level(key_level),
    .press_pulse(press_pulse),
    .release_pulse(release_pulse)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // outputs are sampled 1 time unit after the rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_out(input string tag, input int e, input logic [1:0] lvl,
                           input logic [1:0] prs, input logic [1:0] rel);
    check_eq($sformatf("%s_lvl_e%0d", tag, e), 32'(key_level), 32'(lvl));
    check_eq($sformatf("%s_prs_e%0d", tag, e), 32'(press_pulse), 32'(prs));
    check_eq($sformatf("%s_rel_e%0d", tag, e), 32'(release_pulse), 32'(rel));
  endtask

  initial begin
    // reset with keys released
    rst = 1'b1; key_n = 2'b11;
    repeat (3) tick();
    check_out("rst", 0, 2'b00, 2'b00, 2'b00);
    rst = 1'b0;
    for (int e = 0; e < 10; e++) begin
      tick();
      check_out("idle", e, 2'b00, 2'b00, 2'b00);
    end

    // key 0 pressed and held: pulse at edge 5
    key_n = 2'b10;
    for (int e = 0; e < 8; e++) begin
      tick();
      check_out("press0", e, (e >= 5) ? 2'b01 : 2'b00, (e == 5) ? 2'b01 : 2'b00, 2'b00);
    end

    // key 0 released: release pulse at edge 5
    key_n = 2'b11;
    for (int e = 0; e < 8; e++) begin
      tick();
      check_out("rel0", e, (e < 5) ? 2'b01 : 2'b00, 2'b00, (e == 5) ? 2'b01 : 2'b00);
    end

    // bounce: low 3 edges, high 1, low again -> press at edge 9 only
    for (int e = 0; e < 13; e++) begin
      key_n = (e == 3) ? 2'b11 : 2'b10;
      tick();
      check_out("bounce", e, (e >= 9) ? 2'b01 : 2'b00, (e == 9) ? 2'b01 : 2'b00, 2'b00);
    end

    // release key 0 again
    key_n = 2'b11;
    repeat (8) tick();
    check_out("rel0b", 0, 2'b00, 2'b00, 2'b00);

    // both keys pressed on the same edge
    key_n = 2'b00;
    for (int e = 0; e < 8; e++) begin
      tick();
      check_out("both", e, (e >= 5) ? 2'b11 : 2'b00, (e == 5) ? 2'b11 : 2'b00, 2'b00);
    end
    key_n = 2'b11;
    for (int e = 0; e < 8; e++) begin
      tick();
      check_out("relboth", e, (e < 5) ? 2'b11 : 2'b00, 2'b00, (e == 5) ? 2'b11 : 2'b00);
    end

    // reset while key 1 is in CONFIRM_DOWN with cnt=2, key stays held
    key_n = 2'b01;
    for (int e = 0; e < 4; e++) begin
      tick();
      check_out("pre_rst", e, 2'b00, 2'b00, 2'b00);
    end
    rst = 1'b1;
    for (int e = 0; e < 2; e++) begin
      tick();
      check_out("in_rst", e, 2'b00, 2'b00, 2'b00);
    end
    rst = 1'b0;
    for (int e = 0; e < 8; e++) begin
      tick();
      check_out("post_rst", e, (e >= 5) ? 2'b10 : 2'b00, (e == 5) ? 2'b10 : 2'b00, 2'b00);
    end

    // reset while key 1 is DOWN: no release pulse, level drops
    rst = 1'b1;
    tick();
    check_out("rst_down", 0, 2'b00, 2'b00, 2'b00);
    rst = 1'b0;
    key_n = 2'b11;
    for (int e = 0; e < 8; e++) begin
      tick();
      check_out("after_rst_down", e, 2'b00, 2'b00, 2'b00);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/key_debouncer.md
# key_debouncer

Debounce and edge-detection front end for the DE0-Nano-SoC push-buttons. It sits directly upstream of the stage/counter control logic. It takes the raw, active-low, asynchronous `KEY` pins and synchronizes each one to `clk`. Once a key has held one level for a programmable number of cycles, the block publishes a clean active-high level plus single-cycle press and release strobes for downstream consumers.

## Interface
- `N_KEYS`, default 2: number of independent key channels.
- `DEBOUNCE_CYCLES`, default 1_000_000: consecutive stable synchronized samples required to accept a level change (20 ms at 50 MHz). Legal range is 2 to 2^CNT_W − 1.
- `CNT_W`, default 20: width of each per-key stability counter.

Ports:
- `clk` input 1: system clock, `FPGA_CLK_50` at top level; all logic on its rising edge.
- `rst` input 1: reset, synchronous, active-high.
- `key_n` input N_KEYS: raw board keys, active-low (0 = pressed), asynchronous.
- `key_level` output N_KEYS: debounced state, 1 = pressed.
- `press_pulse` output N_KEYS: one-cycle strobe on each accepted press.
- `release_pulse` output N_KEYS: one-cycle strobe on each accepted release.

## Operation
- Each key has its own channel, built as a generate loop. Channels are fully independent and have no priority between them.
- Synchronizer: two flops per key (`sync1`, `sync2`). The FSM uses the inverted `sync2` as sample `s` (1 = pressed).
- Per-key FSM states:
  - UP: `key_level`=0. If `s`=1: go to CONFIRM_DOWN, cnt←1. Otherwise stay, cnt←0.
  - CONFIRM_DOWN: `key_level`=0.
    - If `s`=0: go to UP, cnt←0, no pulse.
    - Else if cnt = DEBOUNCE_CYCLES−1: go to DOWN, cnt←0, `key_level`←1, `press_pulse`←1.
    - Else cnt←cnt+1.
  - DOWN: `key_level`=1. If `s`=0: go to CONFIRM_UP, cnt←1.
  - CONFIRM_UP: `key_level`=1.
    - If `s`=1: go to DOWN, cnt←0, no pulse.
    - Else if cnt = DEBOUNCE_CYCLES−1: go to UP, cnt←0, `key_level`←0, `release_pulse`←1.
    - Else cnt←cnt+1.
- All outputs are registered.
- Each pulse is high for exactly one cycle and defaults to 0 in every other cycle.
- A key can never assert `press_pulse` and `release_pulse` in the same cycle.
- Glitch rule: any single opposite sample during a CONFIRM state aborts the change completely. The stable state is kept and the count restarts from zero.
- Counter width: cnt never exceeds DEBOUNCE_CYCLES−1, so there is no wrap. CNT_W must hold DEBOUNCE_CYCLES−1.

## Timing
- Reset values:
  - `sync1`/`sync2` = 1, i.e. the released level.
  - All FSMs in UP, all counters 0.
  - `key_level`, `press_pulse`, `release_pulse` all 0.
- Press latency: define edge 0 as the first rising edge at which `key_n` is sampled low.
  - Edges 0–1 fill the synchronizer.
  - Edges 2 through DEBOUNCE_CYCLES+1 must all see `s`=1.
  - At edge DEBOUNCE_CYCLES+1, `press_pulse` and `key_level` go high.
  - `press_pulse` falls at edge DEBOUNCE_CYCLES+2.
- Release latency is symmetric: `release_pulse` and `key_level`=0 appear at edge DEBOUNCE_CYCLES+1, counted from the first edge at which `key_n` is sampled high.
- Key held through reset: `key_level` stays 0 after reset. A normal `press_pulse` follows at edge DEBOUNCE_CYCLES+1 after the first post-reset edge. It counts as a real press.
- Reset mid-CONFIRM or in DOWN: on the next edge the channel returns to UP with outputs 0. No release pulse is generated.
- Bouncing input: any sample sequence shorter than DEBOUNCE_CYCLES consecutive equal samples produces no output change.

## Test plan
All scenarios are run with `DEBOUNCE_CYCLES`=4 and `N_KEYS`=2.
- Reset with key_n=2'b11, then hold 10 cycles → all outputs 0, no pulses.
- key_n[0]=0 from edge 0 and held → `press_pulse[0]`=1 only in the cycle after edge 5; `key_level[0]`=1 from edge 5 onward; key 1 is untouched.
- key_n[0] low for 3 edges, high for 1, then low again → press accepted only 4 stable samples after the final low; exactly one `press_pulse`.
- Pressed key released (key_n[0]=1, held) → `release_pulse[0]`=1 only in the cycle after edge 5; `key_level[0]`=0.
- Both keys pressed on the same edge → both `press_pulse` bits high in the same single cycle.
- `rst` asserted while key 1 is in CONFIRM_DOWN (cnt=2), then `rst` released with the key still held → outputs 0 during reset; `press_pulse[1]` at edge 5 after reset release.
